// File: rtl/hue_pkg.sv
// Shared hue-path constants and the per-stage record of the restoring divider.
package hue_pkg;

    localparam int HUE_DIVIDEND_W     = 8;
    localparam int HUE_DIVISOR_W      = 8;
    localparam int HUE_FRAC_W         = 8;
    // The hue stage-1 delay line is sized from this value, so keep them tied.
    localparam int HUE_DIVIDE_LATENCY = HUE_DIVIDEND_W + HUE_FRAC_W;

    typedef struct packed {
        logic                          vld;
        logic [HUE_DIVISOR_W:0]        rem;
        logic [HUE_DIVISOR_W-1:0]      dvs;
        logic [HUE_DIVIDEND_W-1:0]     dvd;
        logic [HUE_DIVIDE_LATENCY-1:0] quo;
        logic                          dbz;
    } hue_div_stage_t;

endpackage

// File: rtl/hue_div_stage.sv
// One registered restoring-division step; BIT_IDX picks the dividend bit or a zero shift-in.
module hue_div_stage #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 8,
    parameter int QUO_W      = 16,
    parameter int BIT_IDX    = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_vld,
    input  logic [DIVISOR_W:0]    i_rem,
    input  logic [DIVISOR_W-1:0]  i_dvs,
    input  logic [DIVIDEND_W-1:0] i_dvd,
    input  logic [QUO_W-1:0]      i_quo,
    input  logic                  i_dbz,
    output logic                  o_vld,
    output logic [DIVISOR_W:0]    o_rem,
    output logic [DIVISOR_W-1:0]  o_dvs,
    output logic [DIVIDEND_W-1:0] o_dvd,
    output logic [QUO_W-1:0]      o_quo,
    output logic                  o_dbz
);

    logic                  w_bit;
    logic [DIVISOR_W+1:0]  w_rsh;
    logic [DIVISOR_W+1:0]  w_diff;
    logic                  w_ge;
    logic [QUO_W-1:0]      w_quo;

    logic                  r_vld;
    logic [DIVISOR_W:0]    r_rem;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [QUO_W-1:0]      r_quo;
    logic                  r_dbz;

    generate
        if (BIT_IDX < DIVIDEND_W) begin : g_int
            assign w_bit = i_dvd[DIVIDEND_W-1-BIT_IDX];
        end else begin : g_frac
            assign w_bit = 1'b0;
        end
    endgenerate

    // With a nonzero divisor the shifted remainder is below 2*divisor, so the
    // top bit of the difference is exactly the borrow.
    assign w_rsh  = {i_rem, w_bit};
    assign w_diff = w_rsh - {2'b00, i_dvs};
    assign w_ge   = ~w_diff[DIVISOR_W+1];

    always_comb begin
        w_quo                   = i_quo;
        w_quo[QUO_W-1-BIT_IDX]  = w_ge;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) r_vld <= 1'b0;
        else         r_vld <= i_vld;
    end

    always_ff @(posedge i_clk) begin
        if (i_vld) begin
            r_rem <= w_ge ? w_diff[DIVISOR_W:0] : w_rsh[DIVISOR_W:0];
            r_dvs <= i_dvs;
            r_dvd <= i_dvd;
            r_quo <= w_quo;
            r_dbz <= i_dbz;
        end
    end

    assign o_vld = r_vld;
    assign o_rem = r_rem;
    assign o_dvs = r_dvs;
    assign o_dvd = r_dvd;
    assign o_quo = r_quo;
    assign o_dbz = r_dbz;

endmodule

// File: rtl/hue_divider.sv
// Fixed-latency pipelined unsigned divider returning {quotient, fraction} plus a dbz flag.
// HUE_DIV_DBZ_SATURATE_EN: when defined, dbz results drive all-ones data instead of zero.
module hue_divider import hue_pkg::*; #(
    parameter int DIVIDEND_W = HUE_DIVIDEND_W,
    parameter int DIVISOR_W  = HUE_DIVISOR_W,
    parameter int FRAC_W     = HUE_FRAC_W
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic [DIVIDEND_W-1:0]        s_axis_dividend_tdata,
    input  logic                         s_axis_dividend_tvalid,
    input  logic [DIVISOR_W-1:0]         s_axis_divisor_tdata,
    input  logic                         s_axis_divisor_tvalid,
    output logic [DIVIDEND_W+FRAC_W-1:0] m_axis_dout_tdata,
    output logic                         m_axis_dout_tvalid,
    output logic                         m_axis_dout_tuser
);

    localparam int LATENCY = DIVIDEND_W + FRAC_W;

`ifdef HUE_DIV_DBZ_SATURATE_EN
    localparam logic [LATENCY-1:0] DBZ_DATA = '1;
`else
    localparam logic [LATENCY-1:0] DBZ_DATA = '0;
`endif

    logic [LATENCY:0]                 w_vld;
    logic [LATENCY:0][DIVISOR_W:0]    w_rem;
    logic [LATENCY:0][DIVISOR_W-1:0]  w_dvs;
    logic [LATENCY:0][DIVIDEND_W-1:0] w_dvd;
    logic [LATENCY:0][LATENCY-1:0]    w_quo;
    logic [LATENCY:0]                 w_dbz;
    logic                             w_unused;

    logic                             r_vld;
    logic [LATENCY-1:0]               r_data;
    logic                             r_user;

    assign w_vld[0] = s_axis_dividend_tvalid & s_axis_divisor_tvalid;
    assign w_rem[0] = '0;
    assign w_dvs[0] = s_axis_divisor_tdata;
    assign w_dvd[0] = s_axis_dividend_tdata;
    assign w_quo[0] = '0;
    assign w_dbz[0] = (s_axis_divisor_tdata == '0);

    generate
        for (genvar k = 0; k < LATENCY; k++) begin : g_stage
            hue_div_stage #(
                .DIVIDEND_W (DIVIDEND_W),
                .DIVISOR_W  (DIVISOR_W),
                .QUO_W      (LATENCY),
                .BIT_IDX    (k)
            ) u_stage (
                .i_clk  (i_clk),
                .i_rstn (i_rstn),
                .i_vld  (w_vld[k]),
                .i_rem  (w_rem[k]),
                .i_dvs  (w_dvs[k]),
                .i_dvd  (w_dvd[k]),
                .i_quo  (w_quo[k]),
                .i_dbz  (w_dbz[k]),
                .o_vld  (w_vld[k+1]),
                .o_rem  (w_rem[k+1]),
                .o_dvs  (w_dvs[k+1]),
                .o_dvd  (w_dvd[k+1]),
                .o_quo  (w_quo[k+1]),
                .o_dbz  (w_dbz[k+1])
            );
        end
    endgenerate

    // Remainder, divisor and dividend have no consumer past the final step.
    assign w_unused = ^{w_rem[LATENCY], w_dvs[LATENCY], w_dvd[LATENCY]};

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_user <= 1'b0;
        end else begin
            r_vld  <= w_vld[LATENCY];
            r_user <= w_vld[LATENCY] & w_dbz[LATENCY];
            if (!w_vld[LATENCY])     r_data <= '0;
            else if (w_dbz[LATENCY]) r_data <= DBZ_DATA;
            else                     r_data <= w_quo[LATENCY];
        end
    end

    assign m_axis_dout_tvalid = r_vld;
    assign m_axis_dout_tdata  = r_data;
    assign m_axis_dout_tuser  = r_user;

endmodule

// File: tb/tb_hue_divider.sv
// Scoreboard bench for hue_divider: expected results queued at issue, checked by a monitor.
module tb_hue_divider;

    localparam int DW  = 8;
    localparam int SW  = 8;
    localparam int FW  = 8;
    localparam int LAT = DW + FW;
    localparam int OW  = DW + FW;

`ifdef HUE_DIV_DBZ_SATURATE_EN
    localparam logic [OW-1:0] DBZ_D = 16'hFFFF;
`else
    localparam logic [OW-1:0] DBZ_D = 16'h0000;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] dvd_d = '0;
    logic          dvd_v = 1'b0;
    logic [SW-1:0] dvs_d = '0;
    logic          dvs_v = 1'b0;
    logic [OW-1:0] td;
    logic          tv;
    logic          tu;

    hue_divider dut (
        .i_clk                  (clk),
        .i_rstn                 (rstn),
        .s_axis_dividend_tdata  (dvd_d),
        .s_axis_dividend_tvalid (dvd_v),
        .s_axis_divisor_tdata   (dvs_d),
        .s_axis_divisor_tvalid  (dvs_v),
        .m_axis_dout_tdata      (td),
        .m_axis_dout_tvalid     (tv),
        .m_axis_dout_tuser      (tu)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0] d;
        logic          u;
        int            due;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    function automatic logic [OW-1:0] model(int a, int b);
        if (b == 0) return DBZ_D;
        return OW'((a * (1 << FW)) / b);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, req, cyc);
        end
    endtask

    // Inputs are applied on the falling edge and sampled by the next rising edge.
    task automatic drive(bit vd, bit vs, int a, int b, bit rn = 1'b1);
        exp_t e;
        @(negedge clk);
        rstn  = rn;
        dvd_v = vd;
        dvs_v = vs;
        dvd_d = DW'(a);
        dvs_d = SW'(b);
        if (vd && vs && rn) begin
            e.d   = model(a, b);
            e.u   = (b == 0);
            e.due = cyc + LAT + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
    endtask

    int n_acc;
    int k, a, b;

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    while (q.size() > 0 && q[0].due < cyc) begin
                        total++;
                        bad++;
                        $display("FAIL missing_out actual=none required=%0h due=%0d cyc=%0d",
                                 q[0].d, q[0].due, cyc);
                        void'(q.pop_front());
                    end
                    if (tv) begin
                        if (q.size() > 0 && q[0].due == cyc) begin
                            exp_t e;
                            e = q.pop_front();
                            chk("tdata", 32'(td), 32'(e.d));
                            chk("tuser", 32'(tu), 32'(e.u));
                        end else begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_valid actual=1 required=0 tdata=%0h cyc=%0d",
                                     td, cyc);
                        end
                    end else begin
                        chk("idle_zero", 32'({td, tu}), 32'd0);
                    end
                end
            end
        join_none

        // Reset with operands presented: nothing may be accepted.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 5, 3, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        mon_en = 1'b1;
        chk("rst_tvalid", 32'(tv), 32'd0);
        chk("rst_tdata",  32'(td), 32'd0);
        chk("rst_tuser",  32'(tu), 32'd0);

        // Directed single beats, including divide by zero.
        drive(1'b1, 1'b1, 100, 200); idle(20);
        drive(1'b1, 1'b1, 255, 1);   idle(20);
        drive(1'b1, 1'b1, 7, 3);     idle(20);
        drive(1'b1, 1'b1, 0, 5);     idle(20);
        drive(1'b1, 1'b1, 5, 0);     idle(20);
        drive(1'b1, 1'b1, 255, 255); drive(1'b1, 1'b1, 1, 255); idle(20);

        // Lone dividend valid must never produce an output.
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, $urandom_range(0, 255), 0);
        idle(20);

        // Random stream with bubbles and single-sided valids.
        n_acc = 0;
        while (n_acc < 64) begin
            k = $urandom_range(0, 5);
            a = $urandom_range(0, 255);
            b = $urandom_range(1, 255);
            case (k)
                0:       drive(1'b0, 1'b0, a, b);
                1:       drive(1'b1, 1'b0, a, b);
                2:       drive(1'b0, 1'b1, a, b);
                default: begin drive(1'b1, 1'b1, a, b); n_acc++; end
            endcase
        end
        idle(20);

        // Mid-flight reset discards eight in-flight beats.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, $urandom_range(0, 255), $urandom_range(1, 255));
        idle(5);
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        q.delete();
        drive(1'b1, 1'b1, 9, 4);
        idle(25);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
